// File: rtl/mem_spi_flash_responder.sv
// rtl/mem_spi_flash_responder.sv - SPI NOR flash responder (mode 0) bridging a serial controller to a byte store
// Define MEM_SPI_RESP_QUAD_EN to enable quad output fast read (0x6B) gated by QE.
module mem_spi_flash_responder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_cs_n,
    input  logic        in_sclk,
    input  logic [3:0]  in_io,
    output logic [3:0]  out_io,
    output logic [3:0]  io_ena,
    output logic [23:0] out_mem_addr,
    output logic        out_mem_rd,
    input  logic [7:0]  in_mem_rdata,
    output logic        out_mem_wr,
    output logic [7:0]  out_mem_wdata
);
    typedef enum logic [3:0] {
        S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_RD_DATA,
        S_WR_DATA, S_STAT_RD, S_STAT_WR, S_IGNORE
    } state_t;

    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_PROG  = 8'h02;
    localparam logic [7:0] OP_WREN  = 8'h06;
    localparam logic [7:0] OP_WRDI  = 8'h04;
    localparam logic [7:0] OP_RDSR1 = 8'h05;
    localparam logic [7:0] OP_RDSR2 = 8'h35;
    localparam logic [7:0] OP_WRSR2 = 8'h31;
    localparam logic [7:0] OP_QREAD = 8'h6B;

    state_t      r_state;
    state_t      w_next;

    logic [1:0]  r_cs_sync;
    logic [1:0]  r_sclk_sync;
    logic [3:0]  r_io_sync0;
    logic [3:0]  r_io_sync1;
    logic        r_sclk_d;
    logic        r_cs_d;

    logic [4:0]  r_bit_cnt;
    logic [22:0] r_shift;
    logic [7:0]  r_cmd;
    logic [7:0]  r_tx;
    logic [3:0]  r_out;
    logic        r_load;
    logic        r_wel;
    logic        r_qe;
    logic        r_clr_wel;
    logic        r_quad;
    logic        r_sr2_sel;
    logic [23:0] r_addr;
    logic        r_mem_rd;
    logic        r_mem_wr;
    logic [7:0]  r_wdata;

    logic        w_cs;
    logic        w_cs_fall;
    logic        w_rise;
    logic        w_fall;
    logic [23:0] w_shift_next;
    logic [7:0]  w_byte;
    logic [7:0]  w_sr1;
    logic [7:0]  w_sr2;
    logic        w_rd_last;
    logic        w_unused_io;

    assign w_cs         = r_cs_sync[1];
    assign w_cs_fall    = r_cs_d & ~w_cs;
    assign w_rise       = ~w_cs & r_sclk_sync[1] & ~r_sclk_d;
    assign w_fall       = ~w_cs & ~r_sclk_sync[1] & r_sclk_d;
    assign w_shift_next = {r_shift, r_io_sync1[0]};
    assign w_byte       = w_shift_next[7:0];
    assign w_sr1        = {6'b0, r_wel, 1'b0};
    assign w_sr2        = {6'b0, r_qe, 1'b0};
    assign w_rd_last    = r_quad ? (r_bit_cnt == 5'd1) : (r_bit_cnt == 5'd7);
    assign w_unused_io  = ^r_io_sync1[3:1];

    assign out_mem_addr  = r_addr;
    assign out_mem_rd    = r_mem_rd;
    assign out_mem_wr    = r_mem_wr;
    assign out_mem_wdata = r_wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cs_sync   <= 2'b11;
            r_sclk_sync <= 2'b00;
            r_io_sync0  <= 4'h0;
            r_io_sync1  <= 4'h0;
            r_sclk_d    <= 1'b0;
            r_cs_d      <= 1'b1;
        end else begin
            r_cs_sync   <= {r_cs_sync[0], in_cs_n};
            r_sclk_sync <= {r_sclk_sync[0], in_sclk};
            r_io_sync0  <= in_io;
            r_io_sync1  <= r_io_sync0;
            r_sclk_d    <= r_sclk_sync[1];
            r_cs_d      <= w_cs;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (r_state != S_IDLE && w_cs) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: if (w_cs_fall) w_next = S_CMD;
                S_CMD: begin
                    if (w_rise && r_bit_cnt == 5'd7) begin
                        case (w_byte)
                            OP_READ, OP_PROG:   w_next = S_ADDR;
                            OP_RDSR1, OP_RDSR2: w_next = S_STAT_RD;
                            OP_WRSR2:           w_next = S_STAT_WR;
`ifdef MEM_SPI_RESP_QUAD_EN
                            OP_QREAD:           w_next = r_qe ? S_ADDR : S_IGNORE;
`endif
                            default:            w_next = S_IGNORE;
                        endcase
                    end
                end
                S_ADDR: begin
                    if (w_rise && r_bit_cnt == 5'd23) begin
                        if (r_cmd == OP_PROG)       w_next = S_WR_DATA;
                        else if (r_cmd == OP_QREAD) w_next = S_DUMMY;
                        else                        w_next = S_RD_DATA;
                    end
                end
                S_DUMMY:   if (w_rise && r_bit_cnt == 5'd7) w_next = S_RD_DATA;
                S_STAT_WR: if (w_rise && r_bit_cnt == 5'd7) w_next = S_IGNORE;
                default:   w_next = r_state;
            endcase
        end
    end

    // Datapath: shift registers, counters, status bits and memory strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_cmd     <= '0;
            r_tx      <= '0;
            r_out     <= '0;
            r_load    <= 1'b0;
            r_wel     <= 1'b0;
            r_qe      <= 1'b0;
            r_clr_wel <= 1'b0;
            r_quad    <= 1'b0;
            r_sr2_sel <= 1'b0;
            r_addr    <= '0;
            r_mem_rd  <= 1'b0;
            r_mem_wr  <= 1'b0;
            r_wdata   <= '0;
        end else begin
            r_mem_rd <= 1'b0;
            r_mem_wr <= 1'b0;
            r_load   <= r_mem_rd;
            if (r_load) r_tx <= in_mem_rdata;
            // Page wrap applied after the strobe so the strobe carries the byte's own address
            if (r_mem_wr) r_addr[7:0] <= r_addr[7:0] + 8'd1;

            if (w_cs || r_state == S_IDLE) begin
                r_bit_cnt <= '0;
                r_out     <= '0;
                r_clr_wel <= 1'b0;
                r_quad    <= 1'b0;
                if (r_clr_wel) r_wel <= 1'b0;
            end else begin
                case (r_state)
                    S_CMD: begin
                        if (w_rise) begin
                            r_shift   <= w_shift_next[22:0];
                            r_bit_cnt <= r_bit_cnt + 5'd1;
                            if (r_bit_cnt == 5'd7) begin
                                r_bit_cnt <= '0;
                                r_cmd     <= w_byte;
                                case (w_byte)
                                    OP_WREN:           r_wel <= 1'b1;
                                    OP_WRDI:           r_wel <= 1'b0;
                                    OP_PROG, OP_WRSR2: r_clr_wel <= r_wel;
                                    OP_RDSR1: begin
                                        r_tx      <= w_sr1;
                                        r_sr2_sel <= 1'b0;
                                    end
                                    OP_RDSR2: begin
                                        r_tx      <= w_sr2;
                                        r_sr2_sel <= 1'b1;
                                    end
`ifdef MEM_SPI_RESP_QUAD_EN
                                    OP_QREAD:          r_quad <= r_qe;
`endif
                                    default:           r_clr_wel <= 1'b0;
                                endcase
                            end
                        end
                    end
                    S_ADDR: begin
                        if (w_rise) begin
                            r_shift   <= w_shift_next[22:0];
                            r_bit_cnt <= r_bit_cnt + 5'd1;
                            if (r_bit_cnt == 5'd23) begin
                                r_bit_cnt <= '0;
                                r_addr    <= w_shift_next;
                                if (r_cmd != OP_PROG) r_mem_rd <= 1'b1;
                            end
                        end
                    end
                    S_DUMMY: begin
                        if (w_rise) begin
                            r_bit_cnt <= (r_bit_cnt == 5'd7) ? 5'd0 : r_bit_cnt + 5'd1;
                        end
                    end
                    S_RD_DATA: begin
                        if (w_fall) begin
                            if (r_quad) begin
                                r_out <= r_tx[7:4];
                                r_tx  <= {r_tx[3:0], 4'h0};
                            end else begin
                                r_out <= {2'b00, r_tx[7], 1'b0};
                                r_tx  <= {r_tx[6:0], 1'b0};
                            end
                            // Next byte is fetched now so it lands well before the following fall
                            if (w_rd_last) begin
                                r_bit_cnt <= '0;
                                r_addr    <= r_addr + 24'd1;
                                r_mem_rd  <= 1'b1;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 5'd1;
                            end
                        end
                    end
                    S_WR_DATA: begin
                        if (w_rise) begin
                            r_shift   <= w_shift_next[22:0];
                            r_bit_cnt <= r_bit_cnt + 5'd1;
                            if (r_bit_cnt == 5'd7) begin
                                r_bit_cnt <= '0;
                                if (r_wel) begin
                                    r_mem_wr <= 1'b1;
                                    r_wdata  <= w_byte;
                                end
                            end
                        end
                    end
                    S_STAT_RD: begin
                        if (w_fall) begin
                            r_out <= {2'b00, r_tx[7], 1'b0};
                            if (r_bit_cnt == 5'd7) begin
                                r_bit_cnt <= '0;
                                r_tx      <= r_sr2_sel ? w_sr2 : w_sr1;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 5'd1;
                                r_tx      <= {r_tx[6:0], 1'b0};
                            end
                        end
                    end
                    S_STAT_WR: begin
                        if (w_rise) begin
                            r_shift   <= w_shift_next[22:0];
                            r_bit_cnt <= r_bit_cnt + 5'd1;
                            if (r_bit_cnt == 5'd7 && r_wel) r_qe <= w_byte[1];
                        end
                    end
                    default: r_bit_cnt <= r_bit_cnt;
                endcase
            end
        end
    end

    always_comb begin
        io_ena = 4'b0000;
        case (r_state)
`ifdef MEM_SPI_RESP_QUAD_EN
            S_RD_DATA: io_ena = r_quad ? 4'b1111 : 4'b0010;
`else
            S_RD_DATA: io_ena = 4'b0010;
`endif
            S_STAT_RD: io_ena = 4'b0010;
            default:   io_ena = 4'b0000;
        endcase
        out_io = r_out & io_ena;
    end

endmodule

// File: tb/tb_mem_spi_flash_responder.sv
// tb/tb_mem_spi_flash_responder.sv - directed bench for mem_spi_flash_responder
`timescale 1ns/1ps
module tb_mem_spi_flash_responder;
    localparam int HALF = 100;

    logic        clk;
    logic        rst_n;
    logic        in_cs_n;
    logic        in_sclk;
    logic [3:0]  in_io;
    logic [3:0]  out_io;
    logic [3:0]  io_ena;
    logic [23:0] out_mem_addr;
    logic        out_mem_rd;
    logic [7:0]  in_mem_rdata;
    logic        out_mem_wr;
    logic [7:0]  out_mem_wdata;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  mem [logic [23:0]];
    logic [23:0] rd_q[$];
    logic [23:0] wr_a_q[$];
    logic [7:0]  wr_d_q[$];

    mem_spi_flash_responder dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_cs_n       (in_cs_n),
        .in_sclk       (in_sclk),
        .in_io         (in_io),
        .out_io        (out_io),
        .io_ena        (io_ena),
        .out_mem_addr  (out_mem_addr),
        .out_mem_rd    (out_mem_rd),
        .in_mem_rdata  (in_mem_rdata),
        .out_mem_wr    (out_mem_wr),
        .out_mem_wdata (out_mem_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Backing store model and strobe log, sampled mid-cycle
    always @(negedge clk) begin
        if (out_mem_rd) begin
            rd_q.push_back(out_mem_addr);
            in_mem_rdata = mem.exists(out_mem_addr) ? mem[out_mem_addr] : 8'hEE;
        end
        if (out_mem_wr) begin
            wr_a_q.push_back(out_mem_addr);
            wr_d_q.push_back(out_mem_wdata);
        end
    end

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_logs();
        rd_q.delete();
        wr_a_q.delete();
        wr_d_q.delete();
    endtask

    task automatic cs_begin();
        @(negedge clk);
        in_cs_n = 1'b0;
        #HALF;
    endtask

    task automatic cs_end();
        #HALF;
        @(negedge clk);
        in_cs_n = 1'b1;
        #(4 * HALF);
    endtask

    task automatic spi_bit(input logic b, output logic [3:0] pins);
        in_io[0] = b;
        #HALF;
        pins = out_io;
        in_sclk = 1'b1;
        #HALF;
        in_sclk = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        logic [3:0] p;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(tx[i], p);
            rx[i] = p[1];
        end
    endtask

    task automatic spi_cmd(input logic [7:0] op);
        logic [7:0] rx;
        cs_begin();
        spi_byte(op, rx);
        cs_end();
    endtask

    task automatic spi_addr(input logic [23:0] a);
        logic [7:0] rx;
        spi_byte(a[23:16], rx);
        spi_byte(a[15:8], rx);
        spi_byte(a[7:0], rx);
    endtask

    logic [7:0] rx, rx2;
    logic [3:0] nib;

    initial begin
        rst_n = 1'b0; in_cs_n = 1'b1; in_sclk = 1'b0; in_io = 4'h0; in_mem_rdata = 8'h00;
        mem[24'h000010] = 8'hA5; mem[24'h000011] = 8'h3C;
        mem[24'hFFFFFF] = 8'h5A; mem[24'h000000] = 8'h77;
        mem[24'h000020] = 8'hC3;
        repeat (4) @(posedge clk);
        #1;
        expect_eq("rst_io_ena", io_ena, 4'h0);
        expect_eq("rst_out_io", out_io, 4'h0);
        expect_eq("rst_addr", out_mem_addr, 24'h0);
        expect_eq("rst_rd", out_mem_rd, 1'b0);
        expect_eq("rst_wr", out_mem_wr, 1'b0);
        expect_eq("rst_wdata", out_mem_wdata, 8'h00);
        @(negedge clk) rst_n = 1'b1;
        #(4 * HALF);

        // Plain read, two bytes
        clear_logs();
        cs_begin();
        spi_byte(8'h03, rx);
        spi_addr(24'h000010);
        #1 expect_eq("rd_io_ena", io_ena, 4'b0010);
        spi_byte(8'h00, rx);
        spi_byte(8'h00, rx2);
        cs_end();
        expect_eq("rd_byte0", rx, 8'hA5);
        expect_eq("rd_byte1", rx2, 8'h3C);
        expect_eq("rd_fetch0", rd_q.size() > 0 ? rd_q[0] : 24'hDEAD00, 24'h000010);
        expect_eq("rd_fetch1", rd_q.size() > 1 ? rd_q[1] : 24'hDEAD00, 24'h000011);
        expect_eq("rd_idle_ena", io_ena, 4'h0);
        expect_eq("rd_no_wr", wr_a_q.size(), 0);

        // Address wrap at top of the 24-bit space
        clear_logs();
        cs_begin();
        spi_byte(8'h03, rx);
        spi_addr(24'hFFFFFF);
        spi_byte(8'h00, rx);
        spi_byte(8'h00, rx2);
        cs_end();
        expect_eq("wrap_fetch0", rd_q.size() > 0 ? rd_q[0] : 24'hDEAD00, 24'hFFFFFF);
        expect_eq("wrap_fetch1", rd_q.size() > 1 ? rd_q[1] : 24'hDEAD00, 24'h000000);
        expect_eq("wrap_byte0", rx, 8'h5A);
        expect_eq("wrap_byte1", rx2, 8'h77);

        // WEL set/clear and repeated SR1
        spi_cmd(8'h06);
        cs_begin();
        spi_byte(8'h05, rx);
        #1 expect_eq("sr1_io_ena", io_ena, 4'b0010);
        spi_byte(8'h00, rx);
        spi_byte(8'h00, rx2);
        cs_end();
        expect_eq("sr1_wel", rx, 8'h02);
        expect_eq("sr1_repeat", rx2, 8'h02);
        spi_cmd(8'h04);
        cs_begin();
        spi_byte(8'h05, rx); spi_byte(8'h00, rx);
        cs_end();
        expect_eq("sr1_wrdi", rx, 8'h00);

        // Program with page wrap
        clear_logs();
        spi_cmd(8'h06);
        cs_begin();
        spi_byte(8'h02, rx);
        spi_addr(24'h0100FF);
        spi_byte(8'h11, rx);
        spi_byte(8'h22, rx);
        cs_end();
        expect_eq("prog_count", wr_a_q.size(), 2);
        expect_eq("prog_a0", wr_a_q.size() > 0 ? wr_a_q[0] : 24'hDEAD00, 24'h0100FF);
        expect_eq("prog_d0", wr_d_q.size() > 0 ? wr_d_q[0] : 8'hEE, 8'h11);
        expect_eq("prog_a1", wr_a_q.size() > 1 ? wr_a_q[1] : 24'hDEAD00, 24'h010000);
        expect_eq("prog_d1", wr_d_q.size() > 1 ? wr_d_q[1] : 8'hEE, 8'h22);
        expect_eq("prog_no_rd", rd_q.size(), 0);
        cs_begin();
        spi_byte(8'h05, rx); spi_byte(8'h00, rx);
        cs_end();
        expect_eq("prog_sr1_after", rx, 8'h00);

        // Program without WEL
        clear_logs();
        cs_begin();
        spi_byte(8'h02, rx);
        spi_addr(24'h000000);
        spi_byte(8'h55, rx);
        cs_end();
        expect_eq("nowel_no_wr", wr_a_q.size(), 0);

        // SR2 write sets QE, WEL consumed
        spi_cmd(8'h06);
        cs_begin();
        spi_byte(8'h31, rx); spi_byte(8'h02, rx);
        cs_end();
        cs_begin();
        spi_byte(8'h35, rx); spi_byte(8'h00, rx); spi_byte(8'h00, rx2);
        cs_end();
        expect_eq("sr2_qe", rx, 8'h02);
        expect_eq("sr2_repeat", rx2, 8'h02);
        cs_begin();
        spi_byte(8'h05, rx); spi_byte(8'h00, rx);
        cs_end();
        expect_eq("sr2_wel_cleared", rx, 8'h00);

        // Quad output fast read
        clear_logs();
        cs_begin();
        spi_byte(8'h6B, rx);
        spi_addr(24'h000020);
        spi_byte(8'h00, rx);
`ifdef MEM_SPI_RESP_QUAD_EN
        spi_bit(1'b0, nib);
        expect_eq("quad_hi", nib, 4'hC);
        expect_eq("quad_ena", io_ena, 4'b1111);
        spi_bit(1'b0, nib);
        expect_eq("quad_lo", nib, 4'h3);
        cs_end();
        expect_eq("quad_fetch", rd_q.size() > 0 ? rd_q[0] : 24'hDEAD00, 24'h000020);
`else
        spi_bit(1'b0, nib);
        expect_eq("q6b_ignored_ena", io_ena, 4'h0);
        expect_eq("q6b_ignored_io", nib, 4'h0);
        cs_end();
        expect_eq("q6b_no_fetch", rd_q.size(), 0);
`endif

        // Abort after 12 address bits
        clear_logs();
        cs_begin();
        spi_byte(8'h03, rx);
        spi_byte(8'h00, rx);
        for (int i = 0; i < 4; i++) spi_bit(1'b1, nib);
        #HALF;
        cs_end();
        expect_eq("abort_ena", io_ena, 4'h0);
        expect_eq("abort_no_rd", rd_q.size(), 0);
        expect_eq("abort_no_wr", wr_a_q.size(), 0);
        cs_begin();
        spi_byte(8'h05, rx); spi_byte(8'h00, rx);
        cs_end();
        expect_eq("abort_sr1", rx, 8'h00);

        // CS rise during a read returns to idle within 3 clocks
        cs_begin();
        spi_byte(8'h03, rx);
        spi_addr(24'h000010);
        spi_bit(1'b0, nib);
        @(negedge clk) in_cs_n = 1'b1;
        repeat (3) @(posedge clk);
        #1 expect_eq("csrise_3clk_ena", io_ena, 4'h0);
        #(4 * HALF);

        // Reset mid-transaction
        spi_cmd(8'h06);
        cs_begin();
        spi_byte(8'h05, rx);
        spi_bit(1'b0, nib);
        rst_n = 1'b0;
        #1;
        expect_eq("midrst_ena", io_ena, 4'h0);
        expect_eq("midrst_io", out_io, 4'h0);
        in_cs_n = 1'b1;
        #(2 * HALF);
        @(negedge clk) rst_n = 1'b1;
        #(4 * HALF);
        cs_begin();
        spi_byte(8'h05, rx); spi_byte(8'h00, rx);
        cs_end();
        expect_eq("midrst_sr1", rx, 8'h00);
        cs_begin();
        spi_byte(8'h35, rx); spi_byte(8'h00, rx);
        cs_end();
        expect_eq("midrst_sr2", rx, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
